// File: rtl/stream_demux_1to4.sv
// stream_demux_1to4: packet-aware 1-to-4 stream demultiplexer.
// Each beat is steered to one of four channels. The route is latched on the
// first beat of a multi-beat packet and held until its last beat is accepted.
// Every channel owns a one-entry registered slot, so a stalled consumer only
// blocks traffic that is routed to it.
module stream_demux_1to4 #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            in_sel,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [4*DATA_W-1:0]   out_data,
    output logic [3:0]            out_last,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic                  busy,
    output logic [1:0]            cur_sel
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [1:0] lock_sel;
    logic [1:0] route;
    logic       accept;

    // Route selection and input handshake; the slot may accept when empty
    // or when it is being drained in the same cycle.
    always_comb begin
        route    = (state == IDLE) ? in_sel : lock_sel;
        in_ready = !rst && (!out_valid[route] || out_ready[route]);
        accept   = in_valid && in_ready;
    end

    // State register and packet route lock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lock_sel <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && accept && !in_last) begin
                lock_sel <= in_sel;
            end
        end
    end

    // Next-state logic: enter BUSY on a non-final first beat, leave on the last beat.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept && !in_last) state_nx = BUSY;
            BUSY: if (accept && in_last)  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        busy    = (state == BUSY);
        cur_sel = route;
    end

    // Per-channel slots: a load wins over a drain, so a simultaneous
    // drain-and-load keeps the slot occupied with the new beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_last  <= '0;
            out_data  <= '0;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (accept && route == 2'(k)) begin
                    out_valid[k]                 <= 1'b1;
                    out_last[k]                  <= in_last;
                    out_data[k*DATA_W +: DATA_W] <= in_data;
                end else if (out_valid[k] && out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// tb_stream_demux_1to4: directed bench for stream_demux_1to4 with a
// per-channel scoreboard of beats expected to leave each slot.
module tb_stream_demux_1to4;

    localparam int DATA_W = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_sel;
    logic                in_last;
    logic                in_valid;
    logic                in_ready;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]          out_last;
    logic [3:0]          out_valid;
    logic [3:0]          out_ready;
    logic                busy;
    logic [1:0]          cur_sel;

    stream_demux_1to4 #(.DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .cur_sel   (cur_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             sb [4][$];
    logic [3:0]        m_valid;
    logic [DATA_W-1:0] m_data [4];
    logic [3:0]        m_last;
    logic              m_busy;
    logic [1:0]        m_lock;

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [7:0] d,
                         input logic l, input logic [3:0] ordy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_last  = '0;
        m_busy  = 1'b0;
        m_lock  = '0;
        for (int k = 0; k < 4; k++) begin
            m_data[k] = '0;
            sb[k].delete();
        end
    endtask

    // One clock cycle: inputs already driven after a falling edge.
    task automatic step();
        logic [1:0] route;
        logic       exp_ready;
        logic       acc;
        beat_t      b;
        #1;
        route     = m_busy ? m_lock : in_sel;
        exp_ready = !rst && (!m_valid[route] || out_ready[route]);
        acc       = in_valid && exp_ready;
        check("in_ready",  {31'd0, in_ready}, {31'd0, exp_ready});
        check("out_valid", {28'd0, out_valid}, {28'd0, m_valid});
        check("busy",      {31'd0, busy}, {31'd0, m_busy});
        check("cur_sel",   {30'd0, cur_sel}, {30'd0, route});
        for (int k = 0; k < 4; k++) begin
            check($sformatf("out_data[%0d]", k), {24'd0, out_data[k*DATA_W +: DATA_W]}, {24'd0, m_data[k]});
            check($sformatf("out_last[%0d]", k), {31'd0, out_last[k]}, {31'd0, m_last[k]});
        end
        // Drained beats are popped from the scoreboard and compared.
        for (int k = 0; k < 4; k++) begin
            if (m_valid[k] && out_ready[k]) begin
                check($sformatf("sb_nonempty[%0d]", k), {31'd0, sb[k].size() != 0}, 32'd1);
                if (sb[k].size() != 0) begin
                    b = sb[k].pop_front();
                    check($sformatf("sb_data[%0d]", k), {24'd0, out_data[k*DATA_W +: DATA_W]}, {24'd0, b.data});
                    check($sformatf("sb_last[%0d]", k), {31'd0, out_last[k]}, {31'd0, b.last});
                end
            end
        end
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (acc && route == 2'(k)) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = in_data;
                    m_last[k]  = in_last;
                    b.data = in_data;
                    b.last = in_last;
                    sb[k].push_back(b);
                end else if (m_valid[k] && out_ready[k]) begin
                    m_valid[k] = 1'b0;
                end
            end
            if (acc) begin
                if (!m_busy && !in_last) begin
                    m_busy = 1'b1;
                    m_lock = in_sel;
                end else if (m_busy && in_last) begin
                    m_busy = 1'b0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 4'h0);
        model_reset();
        @(negedge clk);

        // Reset state: in_ready low, slots empty and cleared.
        step();
        step();
        rst = 1'b0;

        // 1. Single-beat packets to every channel.
        for (int s = 0; s < 4; s++) begin
            drive(1, 2'(s), 8'hA0 + 8'(s), 1, 4'hF);
            step();
        end
        drive(0, 0, 8'h00, 0, 4'hF);
        step();

        // 2. Route lock: later beats ignore in_sel.
        drive(1, 2, 8'h11, 0, 4'hF); step();
        drive(1, 0, 8'h22, 0, 4'hF); step();
        check("lock_cur_sel", {30'd0, cur_sel}, 32'd2);
        drive(1, 0, 8'h33, 1, 4'hF); step();
        drive(0, 0, 8'h00, 0, 4'hF); step();

        // 3. Backpressure on ch1, then release with drain and load together.
        drive(1, 1, 8'h44, 1, 4'b1101); step();
        drive(1, 1, 8'h55, 1, 4'b1101); step();
        step();
        drive(1, 1, 8'h55, 1, 4'hF); step();
        check("bp_valid1", {31'd0, out_valid[1]}, 32'd1);
        check("bp_data1",  {24'd0, out_data[15:8]}, 32'h55);
        drive(0, 0, 8'h00, 0, 4'hF); step();

        // 4. Channel independence: ch3 stalled, ch0 still accepts.
        drive(1, 3, 8'h66, 1, 4'b0111); step();
        drive(1, 0, 8'h77, 1, 4'b0110); step();
        drive(0, 0, 8'h00, 0, 4'b0110); step();
        check("indep_valid", {28'd0, out_valid}, 32'h9);
        check("indep_ch3",   {24'd0, out_data[31:24]}, 32'h66);
        drive(0, 0, 8'h00, 0, 4'hF); step();

        // 5. Reset in the middle of a packet discards the slot and the lock.
        drive(1, 1, 8'h88, 0, 4'h0); step();
        check("mid_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 4'h0); step();
        rst = 1'b0;
        check("post_rst_valid", {28'd0, out_valid}, 32'h0);
        drive(1, 3, 8'h99, 1, 4'h0); step();
        drive(0, 0, 8'h00, 0, 4'hF); step();

        // 6. Select toggling with no valid beat leaves everything untouched.
        drive(1, 2, 8'h5A, 1, 4'h0); step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 2'(i), 8'($urandom), 1'($urandom), 4'h0);
            step();
        end
        check("idle_valid", {28'd0, out_valid}, 32'h4);
        check("idle_ch2",   {24'd0, out_data[23:16]}, 32'h5A);
        drive(0, 0, 8'h00, 0, 4'hF); step();
        step();

        for (int k = 0; k < 4; k++) begin
            check($sformatf("sb_empty[%0d]", k), sb[k].size(), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    // Bound on total run time in case something stalls.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected finish before 20000");
        $fatal(1, "timeout");
    end

endmodule
